seven_segment_scan_decoder: RTL and testbench

SEVEN_SEGMENT_SCAN_DECODER -- requirements
Module: seven_segment_scan_decoder

---
 rtl/seven_segment_pkg.sv | 30 +++
 rtl/seven_segment_pattern_decode.sv | 35 +++
 rtl/seven_segment_scan_decoder.sv | 150 +++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment scan decoder:
// active-low gfedcba hex patterns and the capture FSM encoding.
package seven_segment_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURED = 2'd2
    } state_e;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0011000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the hex segment encoding.
// Any pattern outside the 16-entry table is reported as not legal.
module seven_segment_pattern_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] gfedcba,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b1;
        case (gfedcba)
            SEG_0:   nibble = 4'h0;
            SEG_1:   nibble = 4'h1;
            SEG_2:   nibble = 4'h2;
            SEG_3:   nibble = 4'h3;
            SEG_4:   nibble = 4'h4;
            SEG_5:   nibble = 4'h5;
            SEG_6:   nibble = 4'h6;
            SEG_7:   nibble = 4'h7;
            SEG_8:   nibble = 4'h8;
            SEG_9:   nibble = 4'h9;
            SEG_A:   nibble = 4'hA;
            SEG_B:   nibble = 4'hB;
            SEG_C:   nibble = 4'hC;
            SEG_D:   nibble = 4'hD;
            SEG_E:   nibble = 4'hE;
            SEG_F:   nibble = 4'hF;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_decoder.sv
// Recovers hex digits from a multiplexed seven-segment display bus.
// A digit is captured once its strobe and pattern stay stable long enough.
module seven_segment_scan_decoder
    import seven_segment_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            gfedcba,
    input  logic [N_DIGITS-1:0]   digit_sel_n,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   digit_valid,
    output logic [N_DIGITS-1:0]   digit_err,
    output logic                  update,
    output logic [2:0]            update_idx
);

    localparam logic [7:0] STAB = 8'(STABLE_CYCLES);

    logic [N_DIGITS-1:0]   sel_q;
    logic [6:0]            pat_q;
    state_e                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [6:0]            lat_q, lat_d;
    logic [4*N_DIGITS-1:0] digits_q;
    logic [N_DIGITS-1:0]   valid_q, err_q;
    logic                  update_q;
    logic [2:0]            upd_idx_q;

    logic                  single;
    logic [2:0]            cur_idx;
    logic                  cap;
    logic [3:0]            dec_nib;
    logic                  dec_legal;

    seven_segment_pattern_decode u_dec (
        .gfedcba (lat_q),
        .nibble  (dec_nib),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '1;
            pat_q <= SEG_BLANK;
        end else begin
            sel_q <= digit_sel_n;
            pat_q <= gfedcba;
        end
    end

    always_comb begin
        single  = $onehot(~sel_q);
        cur_idx = 3'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!sel_q[i]) cur_idx = 3'(i);
        end
    end

    // A capture in SETTLE commits the latched sample; the current
    // sample is then handled exactly as it would be from CAPTURED.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        lat_d   = lat_q;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (single) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                    idx_d   = cur_idx;
                    lat_d   = pat_q;
                end
            end
            ST_SETTLE, ST_CAPTURED: begin
                cap = (state_q == ST_SETTLE) && (cnt_q >= STAB);
                if (!single) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else if (cur_idx != idx_q || pat_q != lat_q) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 8'd1;
                    idx_d   = cur_idx;
                    lat_d   = pat_q;
                end else if (state_q == ST_SETTLE && !cap) begin
                    cnt_d = (cnt_q < STAB) ? cnt_q + 8'd1 : cnt_q;
                end else begin
                    state_d = ST_CAPTURED;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            lat_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            lat_q   <= lat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q  <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            update_q  <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            update_q <= cap;
            if (cap) begin
                upd_idx_q <= idx_q;
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (idx_q == 3'(i)) begin
                        if (dec_legal) begin
                            digits_q[4*i +: 4] <= dec_nib;
                            valid_q[i]         <= 1'b1;
                            err_q[i]           <= 1'b0;
                        end else begin
                            valid_q[i] <= 1'b0;
                            err_q[i]   <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign update      = update_q;
    assign update_idx  = upd_idx_q;

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Directed bench for the seven-segment scan decoder with a
// scoreboard of expected captures checked on every update pulse.
module tb_seven_segment_scan_decoder;

    localparam int N = 4;
    localparam int S = 4;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [3:0] RR [4] = '{4'h1, 4'h7, 4'hE, 4'hF};

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [6:0]     gfedcba = 7'h7F;
    logic [N-1:0]   digit_sel_n = '1;
    logic [4*N-1:0] digits;
    logic [N-1:0]   digit_valid;
    logic [N-1:0]   digit_err;
    logic           update;
    logic [2:0]     update_idx;

    seven_segment_scan_decoder #(
        .N_DIGITS      (N),
        .STABLE_CYCLES (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gfedcba     (gfedcba),
        .digit_sel_n (digit_sel_n),
        .digits      (digits),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .update      (update),
        .update_idx  (update_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] nib;
        logic       legal;
        int         at;
    } exp_t;

    exp_t           q[$];
    exp_t           mon_e;
    logic [4*N-1:0] m_dig = '0;
    logic [N-1:0]   m_val = '0;
    logic [N-1:0]   m_err = '0;
    int             checks = 0;
    int             errors = 0;
    int             n_upd = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sel_idx(input logic [N-1:0] s);
        for (int i = 0; i < N; i++) if (!s[i]) return i;
        return 0;
    endfunction

    task automatic expect_cap(input logic [N-1:0] sel,
                              input logic [6:0] pat);
        exp_t e;
        e.idx   = 3'(sel_idx(sel));
        e.nib   = 4'h0;
        e.legal = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (HEX[k] == pat) begin
                e.nib   = 4'(k);
                e.legal = 1'b1;
            end
        end
        e.at = cyc + S + 2;
        q.push_back(e);
    endtask

    task automatic scan(input logic [N-1:0] sel, input logic [6:0] pat,
                        input int n, input bit cap);
        digit_sel_n = sel;
        gfedcba     = pat;
        if (cap) expect_cap(sel, pat);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        scan('1, 7'h7F, n, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n && update) begin
            n_upd++;
            chk("update_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                mon_e = q.pop_front();
                chk("update_idx", 32'(update_idx), 32'(mon_e.idx));
                chk("update_cycle", 32'(cyc), 32'(mon_e.at));
                if (mon_e.legal) begin
                    m_dig[4*mon_e.idx +: 4] = mon_e.nib;
                    m_val[mon_e.idx] = 1'b1;
                    m_err[mon_e.idx] = 1'b0;
                end else begin
                    m_val[mon_e.idx] = 1'b0;
                    m_err[mon_e.idx] = 1'b1;
                end
                chk("cap_digits", 32'(digits), 32'(m_dig));
                chk("cap_valid", 32'(digit_valid), 32'(m_val));
                chk("cap_err", 32'(digit_err), 32'(m_err));
            end
        end
    end

    initial begin
        logic [4*N-1:0] snap_d;
        logic [N-1:0]   snap_v;
        logic [N-1:0]   snap_e;
        int             u0;

        #22;
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_valid", 32'(digit_valid), 32'd0);
        chk("rst_err", 32'(digit_err), 32'd0);
        chk("rst_update", 32'(update), 32'd0);
        chk("rst_update_idx", 32'(update_idx), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        scan(4'b1110, HEX[2], 6, 1'b1);
        idle(3);
        chk("scan_d0", 32'(digits[3:0]), 32'h2);
        chk("scan_valid", 32'(digit_valid), 32'b0001);

        scan(4'b1101, HEX[3], 3, 1'b0);
        scan(4'b1101, HEX[4], 4, 1'b1);
        idle(3);
        chk("glitch_d1", 32'(digits[7:4]), 32'h4);

        scan(4'b1011, HEX[10], 6, 1'b1);
        idle(2);
        scan(4'b1011, 7'b1111111, 4, 1'b1);
        idle(3);
        chk("blank_err2", 32'(digit_err[2]), 32'd1);
        chk("blank_val2", 32'(digit_valid[2]), 32'd0);
        chk("blank_d2", 32'(digits[11:8]), 32'hA);

        scan(4'b0111, 7'b1010101, 5, 1'b1);
        for (int k = 0; k < 16; k++) scan(4'b0111, HEX[k], 5, 1'b1);
        idle(3);
        chk("sweep_d3", 32'(digits[15:12]), 32'hF);

        snap_d = digits;
        snap_v = digit_valid;
        snap_e = digit_err;
        u0 = n_upd;
        scan(4'b1100, HEX[5], 20, 1'b0);
        idle(3);
        chk("multi_updates", 32'(n_upd - u0), 32'd0);
        chk("multi_digits", 32'(digits), 32'(snap_d));
        chk("multi_valid", 32'(digit_valid), 32'(snap_v));
        chk("multi_err", 32'(digit_err), 32'(snap_e));

        u0 = n_upd;
        for (int r = 0; r < 2; r++) begin
            for (int d = 0; d < 4; d++) begin
                scan(~(4'b0001 << d), HEX[RR[d]], 8, 1'b1);
            end
        end
        idle(3);
        chk("rr_digits", 32'(digits), 32'hFE71);
        chk("rr_updates", 32'(n_upd - u0), 32'd8);
        chk("rr_valid", 32'(digit_valid), 32'hF);
        chk("rr_err", 32'(digit_err), 32'h0);

        scan(4'b1110, HEX[9], 3, 1'b0);
        rst_n = 1'b0;
        m_dig = '0;
        m_val = '0;
        m_err = '0;
        #1;
        chk("arst_digits", 32'(digits), 32'd0);
        chk("arst_valid", 32'(digit_valid), 32'd0);
        chk("arst_update_idx", 32'(update_idx), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        expect_cap(4'b1110, HEX[9]);
        repeat (S + 4) @(posedge clk);
        #1;
        idle(3);
        chk("arst_recap_d0", 32'(digits[3:0]), 32'h9);
        chk("arst_recap_valid", 32'(digit_valid), 32'b0001);
        chk("update_idx_held", 32'(update_idx), 32'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
